// File: rtl/serializer_pkg.sv
// Shared constants for the 16-bit parallel-in / serial-out transmitter.
// Holds the FSM state encoding and the default word width.
package serializer_pkg;

   localparam int DEFAULT_WIDTH = 16;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SHIFT  = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;

endpackage

// File: rtl/sixteen_bit_serializer_bit_counter.sv
// Bit position counter for the serializer: synchronous clear, count enable,
// and a terminal-count flag raised while the count sits at WIDTH-1.
module bit_counter
   import serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear wins over enable so a fresh word always starts from bit 0.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/sixteen_bit_serializer.sv
// Parallel-in, serial-out transmitter. A word is accepted on the edge where
// ld && ready, then shifted out MSB-first with ser_valid high for every bit.
// done pulses on the final bit; ready returns the cycle after.
// Build option: define SERIALIZER_PARITY_EN to append one even-parity bit
// after the data bits (done then moves to the parity cycle).
// All outputs decode from registered state only; ld/in never reach an output
// combinationally.
module sixteen_bit_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] in,
   output logic             ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             done
);

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;
   logic             accept;
   logic             last_bit;

   assign accept = ld && (state_q == S_IDLE);

   bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk   (clk),
      .rst   (rst),
      .clr_i (accept),
      .en_i  (state_q == S_SHIFT),
      .tc_o  (last_bit)
   );

   // Next-state logic: IDLE -> SHIFT on accept, SHIFT leaves after the last bit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (ld) begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (last_bit) begin
`ifdef SERIALIZER_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_IDLE;
`endif
            end
         end
`ifdef SERIALIZER_PARITY_EN
         S_PARITY: begin
            state_d = S_IDLE;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Shift register: load on accept, shift left with zero fill while sending.
   always_comb begin
      shift_d = shift_q;
      if (accept) begin
         shift_d = in;
      end else if (state_q == S_SHIFT) begin
         shift_d = {shift_q[WIDTH-2:0], 1'b0};
      end
   end

   // State and shift registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
      end
   end

`ifdef SERIALIZER_PARITY_EN
   logic parity_q;

   // Parity is taken from the word as captured, so later shifting cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else if (accept) begin
         parity_q <= ^in;
      end
   end

   // Output decode including the trailing parity cycle.
   always_comb begin
      ser_out = 1'b0;
      case (state_q)
         S_SHIFT:  ser_out = shift_q[WIDTH-1];
         S_PARITY: ser_out = parity_q;
         default:  ser_out = 1'b0;
      endcase
   end

   assign done = (state_q == S_PARITY);
`else
   // Output decode: the MSB of the shift register is the current bit.
   always_comb begin
      ser_out = 1'b0;
      if (state_q == S_SHIFT) begin
         ser_out = shift_q[WIDTH-1];
      end
   end

   assign done = (state_q == S_SHIFT) && last_bit;
`endif

   assign ready     = (state_q == S_IDLE);
   assign ser_valid = (state_q != S_IDLE);

endmodule

// File: tb/tb_sixteen_bit_serializer.sv
// Directed bench for sixteen_bit_serializer. Inputs change on the falling
// edge; outputs are sampled on the falling edge, half a cycle after the
// rising edge that produced them.
module tb_sixteen_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
   localparam int NB = 17;
`else
   localparam int NB = 16;
`endif

   logic        clk;
   logic        rst;
   logic        ld;
   logic [15:0] in;
   logic        ready;
   logic        ser_out;
   logic        ser_valid;
   logic        done;

   int checks;
   int failures;

   sixteen_bit_serializer #(
      .WIDTH (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ld        (ld),
      .in        (in),
      .ready     (ready),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   // Bit k of the transmitted stream for word w (index 16 is the parity bit).
   function automatic logic exp_bit(input logic [15:0] w, input int k);
      logic r;
      if (k < 16) r = w[15 - k];
      else        r = ^w;
      return r;
   endfunction

   task automatic test_reset();
      rst = 1; ld = 1; in = 16'hFFFF;
      step(); step();
      rst = 0; ld = 0;
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready); end
      checks++;
      if (ser_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", ser_valid); end
      checks++;
      if (ser_out !== 1'b0) begin failures++; $display("FAIL reset_ser_out got=%b want=0", ser_out); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      step();
      checks++;
      if (ser_valid !== 1'b0 || ready !== 1'b1) begin
         failures++; $display("FAIL rst_ld_no_capture valid=%b ready=%b want 0/1", ser_valid, ready);
      end
   endtask

   task automatic test_aaaa();
      logic [15:0] w;
      w = 16'hAAAA;
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL aaaa_pre_ready got=%b want=1", ready); end
      ld = 1; in = w;
      step();
      ld = 0; in = 16'h0000;
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (ser_valid !== 1'b1 || ready !== 1'b0) begin
            failures++; $display("FAIL aaaa_valid bit%0d valid=%b ready=%b want 1/0", k, ser_valid, ready);
         end
         checks++;
         if (ser_out !== exp_bit(w, k)) begin
            failures++; $display("FAIL aaaa_bit bit%0d got=%b want=%b", k, ser_out, exp_bit(w, k));
         end
         checks++;
         if (done !== (k == NB - 1)) begin
            failures++; $display("FAIL aaaa_done bit%0d got=%b want=%b", k, done, (k == NB - 1));
         end
         step();
      end
      checks++;
      if (ready !== 1'b1 || ser_valid !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL aaaa_after ready=%b valid=%b done=%b want 1/0/0", ready, ser_valid, done);
      end
   endtask

   task automatic test_reassemble();
      logic [16:0] got;
      int          n;
      int          dpos;
      int          guard;
      got = '0; n = 0; dpos = -1; guard = 0;
      ld = 1; in = 16'h8001;
      step();
      ld = 0;
      while (ser_valid === 1'b1 && guard < 40) begin
         got = {got[15:0], ser_out};
         if (done === 1'b1) dpos = n;
         n++; guard++;
         step();
      end
      checks++;
      if (guard >= 40) begin failures++; $display("FAIL r8001_timeout cycles=%0d limit=40", guard); end
      checks++;
      if (n != NB) begin failures++; $display("FAIL r8001_count got=%0d want=%0d", n, NB); end
`ifdef SERIALIZER_PARITY_EN
      checks++;
      if (got !== {16'h8001, 1'b0}) begin failures++; $display("FAIL r8001_word got=%h want=%h", got, {16'h8001, 1'b0}); end
`else
      checks++;
      if (got[15:0] !== 16'h8001) begin failures++; $display("FAIL r8001_word got=%h want=8001", got[15:0]); end
`endif
      checks++;
      if (dpos != NB - 1) begin failures++; $display("FAIL r8001_done_pos got=%0d want=%0d", dpos, NB - 1); end
   endtask

   task automatic test_ld_while_busy();
      logic [15:0] w;
      w = 16'h1234;
      ld = 1; in = w;
      step();
      ld = 0;
      for (int k = 0; k < NB; k++) begin
         if (k == 5) begin ld = 1; in = 16'hFFFF; end
         else if (k == 6) begin ld = 0; in = 16'hFFFF; end
         checks++;
         if (ser_out !== exp_bit(w, k) || ser_valid !== 1'b1) begin
            failures++; $display("FAIL busy_bit bit%0d got=%b valid=%b want=%b", k, ser_out, ser_valid, exp_bit(w, k));
         end
         checks++;
         if (ready !== 1'b0) begin failures++; $display("FAIL busy_ready bit%0d got=%b want=0", k, ready); end
         step();
      end
      in = 16'h0000;
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL busy_ready_after got=%b want=1", ready); end
      step();
      checks++;
      if (ser_valid !== 1'b0) begin failures++; $display("FAIL busy_no_queue valid=%b want=0", ser_valid); end
   endtask

   task automatic test_rst_mid();
      logic [15:0] w;
      w = 16'hFFFF;
      ld = 1; in = w;
      step();
      ld = 0;
      for (int k = 0; k <= 8; k++) begin
         if (k == 8) rst = 1;
         checks++;
         if (ser_out !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL rstmid_bit bit%0d out=%b done=%b want 1/0", k, ser_out, done);
         end
         step();
      end
      rst = 0;
      checks++;
      if (ser_valid !== 1'b0 || ready !== 1'b1 || ser_out !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL rstmid_after valid=%b ready=%b out=%b done=%b want 0/1/0/0",
                              ser_valid, ready, ser_out, done);
      end
      w = 16'h00F0;
      ld = 1; in = w;
      step();
      ld = 0;
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (ser_out !== exp_bit(w, k) || ser_valid !== 1'b1 || done !== (k == NB - 1)) begin
            failures++; $display("FAIL rstmid_reload bit%0d out=%b valid=%b done=%b want %b/1/%b",
                                 k, ser_out, ser_valid, done, exp_bit(w, k), (k == NB - 1));
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a;
      logic [15:0] b;
      a = 16'hAAAA; b = 16'h5555;
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL b2b_pre_ready got=%b want=1", ready); end
      ld = 1; in = a;
      step();
      in = b;
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (ser_out !== exp_bit(a, k) || ser_valid !== 1'b1 || done !== (k == NB - 1)) begin
            failures++; $display("FAIL b2b_a bit%0d out=%b valid=%b done=%b want %b/1/%b",
                                 k, ser_out, ser_valid, done, exp_bit(a, k), (k == NB - 1));
         end
         step();
      end
      checks++;
      if (ready !== 1'b1 || ser_valid !== 1'b0) begin
         failures++; $display("FAIL b2b_gap ready=%b valid=%b want 1/0", ready, ser_valid);
      end
      step();
      ld = 0;
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (ser_out !== exp_bit(b, k) || ser_valid !== 1'b1 || done !== (k == NB - 1)) begin
            failures++; $display("FAIL b2b_b bit%0d out=%b valid=%b done=%b want %b/1/%b",
                                 k, ser_out, ser_valid, done, exp_bit(b, k), (k == NB - 1));
         end
         step();
      end
      checks++;
      if (ready !== 1'b1 || ser_valid !== 1'b0) begin
         failures++; $display("FAIL b2b_end ready=%b valid=%b want 1/0", ready, ser_valid);
      end
   endtask

   task automatic test_parity();
      logic [15:0] w;
      w = 16'h0001;
      ld = 1; in = w;
      step();
      ld = 0;
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (ser_out !== exp_bit(w, k) || done !== (k == NB - 1)) begin
            failures++; $display("FAIL parity_0001 bit%0d out=%b done=%b want %b/%b",
                                 k, ser_out, done, exp_bit(w, k), (k == NB - 1));
         end
         step();
      end
`ifdef SERIALIZER_PARITY_EN
      checks++;
      if (exp_bit(w, 16) !== 1'b1) begin failures++; $display("FAIL parity_model got=%b want=1", exp_bit(w, 16)); end
`endif
      checks++;
      if (ser_valid !== 1'b0 || ready !== 1'b1) begin
         failures++; $display("FAIL parity_end valid=%b ready=%b want 0/1", ser_valid, ready);
      end
   endtask

   initial begin
      clk = 0; rst = 1; ld = 0; in = '0;
      checks = 0; failures = 0;
      step();
      test_reset();
      test_aaaa();
      test_reassemble();
      test_ld_while_busy();
      test_rst_mid();
      test_back_to_back();
      test_parity();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sixteen_bit_serializer.md
Name: sixteen_bit_serializer

Overview:
Parallel-in, serial-out transmitter. It captures a 16-bit word produced by an upstream register using a load/ready handshake, then shifts the word out MSB-first, one bit per clock, with a valid qualifier. It sits at the read end of the datapath's 16-bit register stage and feeds a 1-bit serial link or the bit-serial consumer logic.

Parameters:
WIDTH, 16, data word width in bits; counter width is clog2(WIDTH+1).

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
ld  input  1  load request; word accepted on the edge where ld && ready
in  input  WIDTH  parallel word to transmit
ready  output  1  high when idle and able to accept a word
ser_out  output  1  current serial bit; MSB first
ser_valid  output  1  ser_out carries a valid bit this cycle
done  output  1  one-cycle pulse marking the final serial bit of a word

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, shift register=0, counter=0, ready=1, ser_out=0, ser_valid=0, done=0.
- States:
  - IDLE: ready=1, ser_valid=0.
    - ld=1: capture in into the shift register, clear the counter, go to SHIFT.
    - ld=0: stay in IDLE.
  - SHIFT: ready=0, ser_valid=1, ser_out = shift register MSB.
    - Each edge: shift left by one, fill with 0, counter++.
    - done=1 when counter==WIDTH-1 (last data bit).
    - Next edge after the last bit: go to IDLE.
- Latency:
  - The first bit appears the cycle after the accepting edge.
  - A word occupies exactly WIDTH consecutive ser_valid cycles, with no gaps.
- Throughput:
  - ready rises the cycle after done, so the minimum spacing is WIDTH+1 cycles per word.
  - Back-to-back: ld held high is accepted on the first IDLE edge.
- ld while ready=0: ignored. The in-flight word is unaffected and no request is queued.
- in is sampled only on the accepting edge. Changes to in during SHIFT have no effect.
- rst during SHIFT: the next edge forces every reset value. The partial word is dropped and done is not pulsed.
- rst and ld in the same cycle: rst wins and nothing is captured.
- All outputs are registered or decoded from state only. There are no combinational paths from ld or in to any output.

Optional Feature:
SERIALIZER_PARITY_EN
- Defined:
  - A PARITY state follows the last data bit.
  - ser_out = even parity of the captured word (XOR of all WIDTH bits), with ser_valid=1.
  - done moves to the parity cycle and is not asserted on the last data bit.
  - A word occupies WIDTH+1 valid cycles; spacing is WIDTH+2 cycles.
  - Parity is computed from the captured word at load time and held in a 1-bit register.
- Undefined: no PARITY state and no parity register; behaviour is exactly as above.

Decomposition:
- Shared package serializer_pkg:
  - state encoding localparams S_IDLE, S_SHIFT, S_PARITY (2-bit)
  - default WIDTH constant of 16
- One sub-module is natural: bit_counter (synchronous clear, enable, terminal-count flag at WIDTH-1).
- The shift register stays inline in the top module.

Test Plan:
- Reset then load 16'hAAAA with ld pulsed for one cycle:
  - ser_valid is high for 16 cycles; ser_out = 1,0,1,0,… starting one cycle after the accepting edge.
  - done is high only on the 16th bit; ready returns to 1 on the next cycle.
- Load 16'h8001:
  - ser_out = 1, then fourteen 0s, then 1.
  - The captured word is verified by reassembling the serial bits in the bench.
- Load 16'h1234, then pulse ld with in=16'hFFFF during bit 5:
  - The full 16'h1234 is transmitted; 16'hFFFF is never sent.
  - ready stays 0 until after done.
- Load 16'hFFFF, assert rst at bit 8:
  - The next cycle has ser_valid=0, ready=1, and ser_out=0.
  - No done pulse occurs.
  - A following load of 16'h00F0 transmits correctly.
- Hold ld high with in=16'hAAAA and then 16'h5555:
  - The two words are separated by exactly one idle cycle (ready=1, ser_valid=0).
  - Each word is transmitted intact.
- With SERIALIZER_PARITY_EN defined:
  - 16'hAAAA gives a 17th bit of 0; 16'h0001 gives a 17th bit of 1.
  - done occurs only on the 17th bit.
